load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store controller of the MIPS datapath, directly upstream of the load-data truncator.
//  Takes one pipeline memory request, checks alignment, drives a ready/ack data-memory bus with byte enables.
//  Stalls the pipeline while the access is pending.
//  Returns load data shifted to bit 0, with size/sign, for truncation and extension downstream.
// PARAMETERS
//  TIMEOUT_CYCLES  255  ACCESS cycles without ack before abort (LSU_TIMEOUT_EN only); legal range 1..65535
// PORTS
//  I_LSU_clk        in   1   clock, rising edge
//  I_LSU_rst_n      in   1   reset, asynchronous, active-low
//  I_LSU_valid      in   1   MEM-stage request present
//  I_LSU_we         in   1   1=store, 0=load
//  I_LSU_addr       in   32  byte address
//  I_LSU_wdata      in   32  store data, LSB-justified
//  I_LSU_size       in   2   00=W, 01=H, 10=B, 11=illegal
//  I_LSU_sign       in   1   load sign-extend request (passed through)
//  O_LSU_mem_req    out  1   bus request, held until ack
//  O_LSU_mem_we     out  1   bus write
//  O_LSU_mem_addr   out  32  {addr[31:2],2'b00}
//  O_LSU_mem_be     out  4   byte enables; bit n = lane n = bits [8n+7:8n]
//  O_LSU_mem_wdata  out  32  lane-replicated store data
//  I_LSU_mem_ack    in   1   bus completion, 1-cycle pulse
//  I_LSU_mem_rdata  in   32  read word, valid with ack
//  O_LSU_ld_data    out  32  rdata >> (8*addr[1:0]), registered
//  O_LSU_ld_size    out  2   registered copy of I_LSU_size
//  O_LSU_ld_sign    out  1   registered copy of I_LSU_sign
//  O_LSU_ld_valid   out  1   1-cycle pulse: load result valid
//  O_LSU_stall      out  1   hold the pipeline
//  O_LSU_misalign   out  1   1-cycle pulse: misaligned/illegal request
//  O_LSU_timeout    out  1   1-cycle pulse: bus timeout
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including data, addr, be and the counter.
//  States: IDLE, ACCESS, RESP, ERR.
//   IDLE, valid, aligned   -> ACCESS; latch we/addr/wdata/size/sign.
//   IDLE, valid, misaligned -> ERR. No bus activity in this case.
//   ACCESS: mem_req=1, outputs stable; on ack -> RESP, latch shifted rdata.
//   RESP: one cycle. ld_valid=1 if the request was a load (0 for stores); -> IDLE.
//   ERR: one cycle, misalign or timeout pulse; -> IDLE.
//  I_LSU_valid is ignored in RESP and ERR; the pipeline advances at the end of those cycles.
//  stall = (IDLE & valid) | ACCESS. Minimum latency with ack in the first ACCESS cycle:
//   stall high 2 cycles, result in cycle 3.
//  Misaligned: H with addr[0]=1; W with addr[1:0]!=0; size=11 for any addr.
//  be: B = 0001<<addr[1:0]; H = 0011<<{addr[1],0}; W = 1111. Driven for loads too.
//  wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
//  ld_data upper bits are unmasked; the truncator performs the masking.
//  Ack outside ACCESS is ignored. Reset mid-ACCESS drops mem_req asynchronously, abandons the access,
//   and ignores the late ack.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//   16-bit counter cleared on entry to ACCESS, incremented each ACCESS cycle without ack.
//   When it equals TIMEOUT_CYCLES: drop req, -> ERR, pulse O_LSU_timeout.
//   Ack in the same cycle as the limit: ack wins.
//  LSU_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; O_LSU_timeout tied 0.
// STRUCTURE
//  Package lsu_pkg: size codes SZ_W/SZ_H/SZ_B, state encodings, function is_misaligned(size,addr).
//  Sub-module lsu_lane_align (combinational):
//   generates be and replicated wdata from size/addr[1:0];
//   generates the right-shifted read word from rdata/addr[1:0].
//  Top holds the FSM, request latches and timeout counter.
// TESTING
//  LB sign=1 addr 0x103, ack after 2 wait cycles, rdata 0x80FF1234:
//   be=1000, mem_addr=0x100, ld_data=0x00000080, size=10, sign=1, ld_valid one pulse.
//  SH addr 0x202 wdata 0x0000BEEF, ack immediate:
//   be=1100, mem_wdata=0xBEEFBEEF, we=1, ld_valid stays 0, stall 2 cycles.
//  LW addr 0x105:
//   misalign pulse next cycle, mem_req never asserts, IDLE after ERR.
//  LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack:
//   req high exactly 4 cycles, then timeout pulse. Repeat with ack on cycle 4: RESP, no timeout.
//  rst_n low mid-ACCESS:
//   mem_req falls without waiting for a clock edge; an ack 1 cycle after release is ignored, outputs stay 0.
//  Back-to-back LW 0x10/0x14, zero-wait acks:
//   two ld_valid pulses 3 cycles apart, correct data each.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   size_e           access size codes as carried by the pipeline
//   state_e          load_store_unit FSM state encodings
//   is_misaligned()  1 when (size, addr[1:0]) cannot be issued as one bus beat
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_W = 2'b00,
      SZ_H = 2'b01,
      SZ_B = 2'b10,
      SZ_X = 2'b11   // illegal encoding
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10,
      ST_ERR    = 2'b11
   } state_e;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_W:    return addr_lo != 2'b00;
         SZ_H:    return addr_lo[0];
         SZ_B:    return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
//   size_i    access size (lsu_pkg::size_e encoding)
//   wr_off_i  addr[1:0] of the request being issued
//   wdata_i   LSB-justified store data
//   rd_off_i  addr[1:0] of the access being completed
//   rdata_i   raw bus read word
//   be_o      byte enables, bit n = bits [8n+7:8n]
//   wdata_o   store data replicated across all lanes
//   rdata_o   read word shifted so the addressed byte sits at bit 0
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  wr_off_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  rd_off_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   always_comb begin
      be_o    = 4'b0000;
      wdata_o = wdata_i;
      case (size_i)
         SZ_B: begin
            be_o    = 4'b0001 << wr_off_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         SZ_H: begin
            be_o    = 4'b0011 << {wr_off_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
         end
         SZ_W:    be_o = 4'b1111;
         default: be_o = 4'b0000;
      endcase
   end

   // Upper bits are left unmasked; the downstream truncator masks/extends.
   assign rdata_o = rdata_i >> {rd_off_i, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store controller.
// Accepts one request, checks alignment, runs a req/ack bus access with byte
// enables, stalls the pipeline meanwhile and returns the load word shifted
// to bit 0 together with the request's size/sign for the truncator.
//   I_LSU_clk/I_LSU_rst_n      clock, async active-low reset
//   I_LSU_valid/we/addr/wdata/size/sign   pipeline request
//   O_LSU_mem_req/we/addr/be/wdata, I_LSU_mem_ack/rdata   data-memory bus
//   O_LSU_ld_data/size/sign/valid          load result (valid is a pulse)
//   O_LSU_stall                            pipeline hold
//   O_LSU_misalign / O_LSU_timeout         error pulses
// Optional macro LSU_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES
// cycles without ack. Without it ACCESS waits forever and timeout is 0.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        I_LSU_clk,
   input  logic        I_LSU_rst_n,
   input  logic        I_LSU_valid,
   input  logic        I_LSU_we,
   input  logic [31:0] I_LSU_addr,
   input  logic [31:0] I_LSU_wdata,
   input  logic [1:0]  I_LSU_size,
   input  logic        I_LSU_sign,
   output logic        O_LSU_mem_req,
   output logic        O_LSU_mem_we,
   output logic [31:0] O_LSU_mem_addr,
   output logic [3:0]  O_LSU_mem_be,
   output logic [31:0] O_LSU_mem_wdata,
   input  logic        I_LSU_mem_ack,
   input  logic [31:0] I_LSU_mem_rdata,
   output logic [31:0] O_LSU_ld_data,
   output logic [1:0]  O_LSU_ld_size,
   output logic        O_LSU_ld_sign,
   output logic        O_LSU_ld_valid,
   output logic        O_LSU_stall,
   output logic        O_LSU_misalign,
   output logic        O_LSU_timeout
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   state_e      state_q;
   logic        mem_req_q, mem_we_q;
   logic [31:0] mem_addr_q, mem_wdata_q, ld_data_q;
   logic [3:0]  mem_be_q;
   logic [1:0]  off_q, ld_size_q;
   logic        ld_sign_q, ld_valid_q, misalign_q;
   logic [3:0]  be_c;
   logic [31:0] wdata_c, rshift_c;

   lsu_lane_align u_align (
      .size_i   (I_LSU_size),
      .wr_off_i (I_LSU_addr[1:0]),
      .wdata_i  (I_LSU_wdata),
      .rd_off_i (off_q),
      .rdata_i  (I_LSU_mem_rdata),
      .be_o     (be_c),
      .wdata_o  (wdata_c),
      .rdata_o  (rshift_c)
   );

`ifdef LSU_TIMEOUT_EN
   logic        timeout_q;
   logic [15:0] cnt_q, cnt_d;
   assign cnt_d = cnt_q + 16'd1;
`endif

   always_ff @(posedge I_LSU_clk or negedge I_LSU_rst_n) begin
      if (!I_LSU_rst_n) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         off_q       <= '0;
         ld_data_q   <= '0;
         ld_size_q   <= '0;
         ld_sign_q   <= 1'b0;
         ld_valid_q  <= 1'b0;
         misalign_q  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         timeout_q   <= 1'b0;
         cnt_q       <= '0;
`endif
      end else begin
         // Status outputs are single-cycle pulses.
         ld_valid_q <= 1'b0;
         misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         timeout_q  <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: if (I_LSU_valid) begin
               if (is_misaligned(I_LSU_size, I_LSU_addr[1:0])) begin
                  state_q    <= ST_ERR;
                  misalign_q <= 1'b1;
               end else begin
                  state_q     <= ST_ACCESS;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= I_LSU_we;
                  mem_addr_q  <= {I_LSU_addr[31:2], 2'b00};
                  mem_be_q    <= be_c;
                  mem_wdata_q <= wdata_c;
                  off_q       <= I_LSU_addr[1:0];
                  ld_size_q   <= I_LSU_size;
                  ld_sign_q   <= I_LSU_sign;
`ifdef LSU_TIMEOUT_EN
                  cnt_q       <= '0;
`endif
               end
            end
            ST_ACCESS: begin
               // Ack takes priority over a timeout reached in the same cycle.
               if (I_LSU_mem_ack) begin
                  state_q    <= ST_RESP;
                  mem_req_q  <= 1'b0;
                  mem_we_q   <= 1'b0;
                  ld_data_q  <= rshift_c;
                  ld_valid_q <= ~mem_we_q;
               end
`ifdef LSU_TIMEOUT_EN
               else if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
                  state_q   <= ST_ERR;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
`endif
            end
            default: state_q <= ST_IDLE;   // RESP and ERR last one cycle
         endcase
      end
   end

   assign O_LSU_mem_req   = mem_req_q;
   assign O_LSU_mem_we    = mem_we_q;
   assign O_LSU_mem_addr  = mem_addr_q;
   assign O_LSU_mem_be    = mem_be_q;
   assign O_LSU_mem_wdata = mem_wdata_q;
   assign O_LSU_ld_data   = ld_data_q;
   assign O_LSU_ld_size   = ld_size_q;
   assign O_LSU_ld_sign   = ld_sign_q;
   assign O_LSU_ld_valid  = ld_valid_q;
   assign O_LSU_misalign  = misalign_q;
   assign O_LSU_stall     = (state_q == ST_IDLE && I_LSU_valid) || state_q == ST_ACCESS;
`ifdef LSU_TIMEOUT_EN
   assign O_LSU_timeout   = timeout_q;
`else
   assign O_LSU_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single requests plus
// hand-written sequences for wait states, back-to-back loads, reset during
// an access and (with LSU_TIMEOUT_EN) the bus timeout.
module tb_load_store_unit;

   logic        clk, rst_n;
   logic        valid, we, sign, ack;
   logic [31:0] addr, wdata, rdata;
   logic [1:0]  size;
   logic        mem_req, mem_we, ld_sign, ld_valid, stall, misalign, timeout;
   logic [31:0] mem_addr, mem_wdata, ld_data;
   logic [3:0]  mem_be;
   logic [1:0]  ld_size;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .I_LSU_clk(clk), .I_LSU_rst_n(rst_n), .I_LSU_valid(valid), .I_LSU_we(we),
      .I_LSU_addr(addr), .I_LSU_wdata(wdata), .I_LSU_size(size), .I_LSU_sign(sign),
      .O_LSU_mem_req(mem_req), .O_LSU_mem_we(mem_we), .O_LSU_mem_addr(mem_addr),
      .O_LSU_mem_be(mem_be), .O_LSU_mem_wdata(mem_wdata), .I_LSU_mem_ack(ack),
      .I_LSU_mem_rdata(rdata), .O_LSU_ld_data(ld_data), .O_LSU_ld_size(ld_size),
      .O_LSU_ld_sign(ld_sign), .O_LSU_ld_valid(ld_valid), .O_LSU_stall(stall),
      .O_LSU_misalign(misalign), .O_LSU_timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic sg);
      valid = 1'b1; we = w; addr = a; wdata = d; size = s; sign = sg;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] rdata;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] mwdata;
      logic [31:0] ld;
   } vec_t;

   vec_t vt[13];

   initial begin
      int n_req, n_to, to_at;
      vt[0]  = '{0, 32'h103, 32'h0,        2'b10, 1, 32'h80FF1234, 0, 4'b1000, 32'h0,        32'h00000080};
      vt[1]  = '{0, 32'h102, 32'h0,        2'b01, 0, 32'h80FF1234, 0, 4'b1100, 32'h0,        32'h000080FF};
      vt[2]  = '{0, 32'h200, 32'h0,        2'b00, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF};
      vt[3]  = '{0, 32'h201, 32'h0,        2'b10, 1, 32'h11223344, 0, 4'b0010, 32'h0,        32'h00112233};
      vt[4]  = '{0, 32'h100, 32'h0,        2'b10, 0, 32'hAABBCCDD, 0, 4'b0001, 32'h0,        32'hAABBCCDD};
      vt[5]  = '{1, 32'h302, 32'h123456A5, 2'b10, 0, 32'h0,        0, 4'b0100, 32'hA5A5A5A5, 32'h0};
      vt[6]  = '{1, 32'h200, 32'hFFFF1234, 2'b01, 0, 32'h0,        0, 4'b0011, 32'h12341234, 32'h0};
      vt[7]  = '{1, 32'h400, 32'hCAFEF00D, 2'b00, 0, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 32'h0};
      vt[8]  = '{0, 32'h101, 32'h0,        2'b01, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0};
      vt[9]  = '{0, 32'h106, 32'h0,        2'b00, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0};
      vt[10] = '{0, 32'h100, 32'h0,        2'b11, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0};
      vt[11] = '{1, 32'h103, 32'h0,        2'b01, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0};
      vt[12] = '{0, 32'h105, 32'h0,        2'b00, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0};

      valid = 0; we = 0; addr = 0; wdata = 0; size = 0; sign = 0; ack = 0; rdata = 0;
      rst_n = 1'b0;
      #23;
      chk("rst_req", mem_req, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_lddata", ld_data, 0);
      chk("rst_stall", stall, 0);
      chk("rst_flags", {ld_valid, misalign, timeout, mem_we}, 0);
      rst_n = 1'b1;
      cyc();

      // ---- table-driven single requests, zero-wait ack ----
      foreach (vt[i]) begin
         cyc();
         req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].sign);
         #1 chk($sformatf("v%0d_stall_idle", i), stall, 1);
         cyc();
         if (vt[i].mis) begin
            valid = 0;
            #1 chk($sformatf("v%0d_misalign", i), misalign, 1);
            chk($sformatf("v%0d_noreq", i), mem_req, 0);
            chk($sformatf("v%0d_stall_err", i), stall, 0);
            cyc();
            #1 chk($sformatf("v%0d_mis_pulse", i), misalign, 0);
         end else begin
            ack = 1; rdata = vt[i].rdata;
            #1 chk($sformatf("v%0d_req", i), mem_req, 1);
            chk($sformatf("v%0d_we", i), mem_we, vt[i].we);
            chk($sformatf("v%0d_be", i), mem_be, vt[i].be);
            chk($sformatf("v%0d_maddr", i), mem_addr, {vt[i].addr[31:2], 2'b00});
            if (vt[i].we) chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].mwdata);
            cyc();
            ack = 0; valid = 0;
            #1 chk($sformatf("v%0d_ldvalid", i), ld_valid, !vt[i].we);
            if (!vt[i].we) chk($sformatf("v%0d_lddata", i), ld_data, vt[i].ld);
            chk($sformatf("v%0d_resp_req", i), mem_req, 0);
            chk($sformatf("v%0d_stall_resp", i), stall, 0);
            cyc();
            #1 chk($sformatf("v%0d_ldv_pulse", i), ld_valid, 0);
         end
      end

      // ---- LB 0x103 with two wait cycles ----
      cyc();
      req(0, 32'h103, 0, 2'b10, 1);
      #1 chk("lbw_stall0", stall, 1);
      cyc();
      #1 chk("lbw_req1", mem_req, 1);
      chk("lbw_be", mem_be, 4'b1000);
      chk("lbw_addr", mem_addr, 32'h100);
      cyc();
      #1 chk("lbw_req2", {mem_req, stall}, 2'b11);
      cyc();
      ack = 1; rdata = 32'h80FF1234;
      #1 chk("lbw_req3", {mem_req, stall, ld_valid}, 3'b110);
      cyc();
      ack = 0; valid = 0;
      #1 chk("lbw_ldvalid", ld_valid, 1);
      chk("lbw_lddata", ld_data, 32'h00000080);
      chk("lbw_size_sign", {ld_size, ld_sign}, 3'b101);
      chk("lbw_stall_resp", stall, 0);
      cyc();
      #1 chk("lbw_ldv_pulse", ld_valid, 0);

      // ---- SH 0x202, immediate ack ----
      cyc();
      req(1, 32'h202, 32'h0000BEEF, 2'b01, 0);
      #1 chk("sh_stall0", stall, 1);
      cyc();
      ack = 1;
      #1 chk("sh_bus", {mem_req, mem_we, mem_be}, 6'b111100);
      chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
      chk("sh_stall1", stall, 1);
      cyc();
      ack = 0; valid = 0;
      #1 chk("sh_resp", {ld_valid, stall, mem_req}, 3'b000);
      cyc();
      #1 chk("sh_after", ld_valid, 0);

      // ---- back-to-back LW 0x10 / 0x14 ----
      cyc();
      req(0, 32'h10, 0, 2'b00, 0);
      #1 chk("b2b_stall0", stall, 1);
      cyc();
      ack = 1; rdata = 32'h11111111;
      #1 chk("b2b_addr0", mem_addr, 32'h10);
      cyc();
      ack = 0; addr = 32'h14;   // presented during RESP, must wait for IDLE
      #1 chk("b2b_ldv0", ld_valid, 1);
      chk("b2b_data0", ld_data, 32'h11111111);
      chk("b2b_stall_resp", stall, 0);
      cyc();
      #1 chk("b2b_idle", {ld_valid, mem_req, stall}, 3'b001);
      cyc();
      ack = 1; rdata = 32'h22222222;
      #1 chk("b2b_addr1", mem_addr, 32'h14);
      cyc();
      ack = 0; valid = 0;
      #1 chk("b2b_ldv1", ld_valid, 1);
      chk("b2b_data1", ld_data, 32'h22222222);
      cyc();

`ifdef LSU_TIMEOUT_EN
      // ---- no ack: req high for exactly 4 cycles, then timeout ----
      n_req = 0; n_to = 0; to_at = -1;
      cyc();
      req(0, 32'h80, 0, 2'b00, 0);
      for (int k = 0; k < 10; k++) begin
         cyc();
         valid = 0;
         #1;
         if (mem_req) n_req++;
         if (timeout) begin n_to++; to_at = k; end
      end
      chk("to_req_cycles", n_req, 4);
      chk("to_pulses", n_to, 1);
      chk("to_when", to_at, 4);

      // ---- ack on the 4th ACCESS cycle wins ----
      cyc();
      req(0, 32'h84, 0, 2'b00, 0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         valid = 0;
      end
      cyc();
      ack = 1; rdata = 32'h0BADF00D;
      #1 chk("toack_req4", mem_req, 1);
      cyc();
      ack = 0;
      #1 chk("toack_resp", {ld_valid, timeout}, 2'b10);
      chk("toack_data", ld_data, 32'h0BADF00D);
      cyc();
      #1 chk("toack_after", timeout, 0);
`else
      n_req = 0; n_to = 0; to_at = 0;
      chk("no_timeout", timeout, 0);
`endif

      // ---- reset during ACCESS, then a stray ack ----
      cyc();
      req(0, 32'h40, 0, 2'b00, 0);
      cyc();
      #1 chk("rst_mid_req", mem_req, 1);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_drop", mem_req, 0);
      valid = 0;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      ack = 1; rdata = 32'hFFFFFFFF;
      cyc();
      ack = 0;
      #1 chk("rst_late_ack", {ld_valid, mem_req, stall, misalign}, 4'b0000);
      chk("rst_late_data", ld_data, 0);
      chk("rst_late_be", mem_be, 0);
      cyc();
      #1 chk("rst_late_ldv", ld_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
